y86_execute_stage: RTL and testbench

Registered execute stage of the Y-86 sequential datapath: takes decoded operands, computes valE with a 64-bit add/sub/and/xor core, maintains the condition-code register (ZF, SF, OF) and evaluates the branch/cmov condition Cnd. It sits between decode (upstream) and memory (downstream). It holds one result in an output register under a valid/ready handshake.

---
 rtl/y86_pkg.sv | 37 +++
 rtl/y86_alu_core.sv | 36 +++
 rtl/y86_execute_stage.sv | 127 ++++++++++++
 tb/tb_y86_execute_stage.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y-86 encodings for the execute stage: instruction codes, ALU ops,
// branch/cmov conditions and condition-code bit positions.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2,
        ALU_XOR = 2'd3
    } alu_op_e;

    localparam logic [3:0] C_YES = 4'h0;
    localparam logic [3:0] C_LE  = 4'h1;
    localparam logic [3:0] C_L   = 4'h2;
    localparam logic [3:0] C_E   = 4'h3;
    localparam logic [3:0] C_NE  = 4'h4;
    localparam logic [3:0] C_GE  = 4'h5;
    localparam logic [3:0] C_G   = 4'h6;

    localparam int CC_ZF = 2;
    localparam int CC_SF = 1;
    localparam int CC_OF = 0;

endpackage

// File: rtl/y86_alu_core.sv
// Combinational 64-bit ALU: aluB op aluA with zero/sign/overflow flags.
module y86_alu_core
    import y86_pkg::*;
(
    input  logic [63:0] aluA,
    input  logic [63:0] aluB,
    input  alu_op_e     op,
    output logic [63:0] result,
    output logic        zf,
    output logic        sf,
    output logic        of
);

    logic        sub;
    logic [63:0] a_in;
    logic [63:0] sum;

    // Subtraction is aluB + ~aluA + 1, so one adder serves both ops.
    assign sub  = (op == ALU_SUB);
    assign a_in = sub ? ~aluA : aluA;
    assign sum  = aluB + a_in + {63'd0, sub};

    always_comb begin
        result = sum;
        of     = (aluB[63] == a_in[63]) && (sum[63] != aluB[63]);
        case (op)
            ALU_AND: begin result = aluB & aluA; of = 1'b0; end
            ALU_XOR: begin result = aluB ^ aluA; of = 1'b0; end
            default: ;
        endcase
    end

    assign zf = (result == 64'd0);
    assign sf = result[63];

endmodule

// File: rtl/y86_execute_stage.sv
// Y-86 execute stage: operand select, ALU, CC register, Cnd evaluation and a
// single-entry output register under valid/ready.
module y86_execute_stage
    import y86_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  icode,
    input  logic [3:0]  ifun,
    input  logic [63:0] valA,
    input  logic [63:0] valB,
    input  logic [63:0] valC,
    input  logic        cc_hold,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_icode,
    output logic [63:0] valE,
    output logic        cnd,
    output logic [2:0]  cc,
    output logic        out_err
);

    logic [63:0] alu_a, alu_b, alu_res, valE_d, valE_q;
    alu_op_e     alu_op;
    logic        alu_zf, alu_sf, alu_of;
    logic        zero_e, err_d, cc_en, cnd_d;
    logic        out_valid_q, cnd_q, err_q;
    logic [3:0]  icode_q;
    logic [2:0]  cc_q;
    logic        zf, sf, of, accept;

    assign zf = cc_q[CC_ZF];
    assign sf = cc_q[CC_SF];
    assign of = cc_q[CC_OF];

    y86_alu_core u_alu (
        .aluA   (alu_a),
        .aluB   (alu_b),
        .op     (alu_op),
        .result (alu_res),
        .zf     (alu_zf),
        .sf     (alu_sf),
        .of     (alu_of)
    );

    always_comb begin
        alu_a  = 64'd0;
        alu_b  = 64'd0;
        alu_op = ALU_ADD;
        zero_e = 1'b0;
        err_d  = 1'b0;
        cc_en  = 1'b0;
        cnd_d  = 1'b1;
        case (icode)
            I_HALT, I_NOP, I_JXX: zero_e = 1'b1;
            I_RRMOVQ:             alu_a = valA;
            I_IRMOVQ:             alu_a = valC;
            I_RMMOVQ, I_MRMOVQ: begin alu_a = valC; alu_b = valB; end
            I_OPQ: begin
                alu_a = valA;
                alu_b = valB;
                if (ifun > 4'd3) begin
                    err_d  = 1'b1;
                    zero_e = 1'b1;
                end else begin
                    alu_op = alu_op_e'(ifun[1:0]);
                    cc_en  = !cc_hold;
                end
            end
            I_CALL, I_PUSHQ: begin alu_a = 64'd8; alu_b = valB; alu_op = ALU_SUB; end
            I_RET, I_POPQ:   begin alu_a = 64'd8; alu_b = valB; end
            default: begin err_d = 1'b1; zero_e = 1'b1; end
        endcase

        // Conditions read the CC as it stood before this instruction.
        if (icode == I_RRMOVQ || icode == I_JXX) begin
            case (ifun)
                C_YES:   cnd_d = 1'b1;
                C_LE:    cnd_d = (sf ^ of) | zf;
                C_L:     cnd_d = sf ^ of;
                C_E:     cnd_d = zf;
                C_NE:    cnd_d = !zf;
                C_GE:    cnd_d = !(sf ^ of);
                C_G:     cnd_d = !(sf ^ of) & !zf;
                default: begin cnd_d = 1'b0; err_d = 1'b1; end
            endcase
        end
    end

    assign valE_d   = zero_e ? 64'd0 : alu_res;
    assign in_ready = !out_valid_q | out_ready;
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            valE_q      <= 64'd0;
            icode_q     <= 4'd0;
            cnd_q       <= 1'b0;
            err_q       <= 1'b0;
            cc_q        <= 3'b100;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            valE_q      <= valE_d;
            icode_q     <= icode;
            cnd_q       <= cnd_d;
            err_q       <= err_d;
            if (cc_en) begin
                cc_q[CC_ZF] <= alu_zf;
                cc_q[CC_SF] <= alu_sf;
                cc_q[CC_OF] <= alu_of;
            end
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_icode = icode_q;
    assign valE      = valE_q;
    assign cnd       = cnd_q;
    assign out_err   = err_q;
    assign cc        = cc_q;

endmodule

// File: tb/tb_y86_execute_stage.sv
// Scoreboard bench for y86_execute_stage: an independent reference model
// predicts each accepted instruction, a monitor checks results on consumption.
module tb_y86_execute_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, cc_hold, out_valid, out_ready, cnd, out_err;
    logic [3:0]  icode, ifun, out_icode;
    logic [63:0] valA, valB, valC, valE;
    logic [2:0]  cc;

    typedef struct packed {
        logic [3:0]  icode;
        logic [63:0] vale;
        logic        cnd;
        logic        err;
        logic [2:0]  cc;
    } exp_t;

    exp_t       sb[$];
    logic [2:0] m_cc;
    int         total = 0;
    int         bad   = 0;

    always #5 clk = ~clk;

    y86_execute_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .icode(icode), .ifun(ifun), .valA(valA), .valB(valB), .valC(valC),
        .cc_hold(cc_hold), .out_valid(out_valid), .out_ready(out_ready),
        .out_icode(out_icode), .valE(valE), .cnd(cnd), .cc(cc), .out_err(out_err)
    );

    // Reference model: signed overflow from a 65-bit sign-extended result.
    task automatic predict(input logic [3:0] ic, input logic [3:0] fn,
                           input logic [63:0] a, input logic [63:0] b,
                           input logic [63:0] c, input logic hold);
        exp_t        e;
        logic [64:0] s;
        logic        zf = m_cc[2];
        logic        sf = m_cc[1];
        logic        of = m_cc[0];
        logic        nof = 1'b0;
        e.icode = ic; e.vale = 64'd0; e.err = 1'b0; e.cnd = 1'b1;
        case (ic)
            4'h0, 4'h1, 4'h7: ;
            4'h2: e.vale = a;
            4'h3: e.vale = c;
            4'h4, 4'h5: e.vale = b + c;
            4'h8, 4'hA: e.vale = b - 64'd8;
            4'h9, 4'hB: e.vale = b + 64'd8;
            4'h6: case (fn)
                4'h0: begin s = {b[63], b} + {a[63], a}; e.vale = s[63:0]; nof = s[64] ^ s[63]; end
                4'h1: begin s = {b[63], b} - {a[63], a}; e.vale = s[63:0]; nof = s[64] ^ s[63]; end
                4'h2: e.vale = a & b;
                4'h3: e.vale = a ^ b;
                default: e.err = 1'b1;
            endcase
            default: e.err = 1'b1;
        endcase
        if (ic == 4'h2 || ic == 4'h7) begin
            case (fn)
                4'h0: e.cnd = 1'b1;
                4'h1: e.cnd = (sf != of) || zf;
                4'h2: e.cnd = (sf != of);
                4'h3: e.cnd = zf;
                4'h4: e.cnd = !zf;
                4'h5: e.cnd = (sf == of);
                4'h6: e.cnd = (sf == of) && !zf;
                default: begin e.cnd = 1'b0; e.err = 1'b1; end
            endcase
        end
        if (ic == 4'h6 && fn < 4'h4 && !hold)
            m_cc = {e.vale == 64'd0, e.vale[63], nof};
        e.cc = m_cc;
        sb.push_back(e);
    endtask

    task automatic send(input logic [3:0] ic, input logic [3:0] fn,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] c, input logic hold);
        int n = 0;
        icode = ic; ifun = fn; valA = a; valB = b; valC = c; cc_hold = hold;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 20) begin @(negedge clk); n++; end
        if (!in_ready) begin
            total++; bad++;
            $display("FAIL accept_timeout: in_ready=%b required 1", in_ready);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        predict(ic, fn, a, b, c, hold);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 50) begin @(negedge clk); n++; end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d results outstanding, required 0", sb.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        total++;
        if ({out_valid, in_ready, cc, valE, out_icode, cnd, out_err} !== {1'b0, 1'b1, 3'b100, 64'd0, 4'd0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset: valid=%b rdy=%b cc=%b valE=%h ic=%h cnd=%b err=%b required 0 1 100 0 0 0 0",
                     out_valid, in_ready, cc, valE, out_icode, cnd, out_err);
        end
        @(posedge clk); #1 rst = 1'b0;
        m_cc = 3'b100;
    endtask

    task automatic test_alu();
        send(4'h6, 4'h0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0);
        send(4'h6, 4'h1, 64'd1, 64'h8000_0000_0000_0000, 64'd0, 1'b0);
        send(4'h6, 4'h3, 64'h5A, 64'h5A, 64'd0, 1'b0);
        send(4'h7, 4'h3, 64'd0, 64'd0, 64'h40, 1'b0);
        send(4'h7, 4'h4, 64'd0, 64'd0, 64'h40, 1'b0);
        send(4'h6, 4'h2, 64'hF0F0, 64'h0FF0, 64'd0, 1'b0);
        send(4'h6, 4'h0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 1'b0);
        for (int f = 0; f < 7; f++)
            send(4'h7, f[3:0], 64'd0, 64'd0, 64'd0, 1'b0);
        send(4'h2, 4'h1, 64'h77, 64'd0, 64'd0, 1'b0);
        drain();
    endtask

    task automatic test_addr();
        send(4'hA, 4'h0, 64'd0, 64'h100, 64'd0, 1'b0);
        send(4'hB, 4'h0, 64'd0, 64'h100, 64'd0, 1'b0);
        send(4'h5, 4'h0, 64'd0, 64'h10, 64'h20, 1'b0);
        send(4'h4, 4'h0, 64'd0, 64'h8, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0);
        send(4'h3, 4'h0, 64'd9, 64'd9, 64'h1234, 1'b0);
        send(4'h8, 4'h0, 64'd0, 64'h0, 64'd0, 1'b0);
        send(4'h9, 4'h0, 64'd0, 64'h200, 64'd0, 1'b0);
        send(4'h0, 4'h0, 64'd5, 64'd6, 64'd7, 1'b0);
        send(4'h1, 4'h0, 64'd5, 64'd6, 64'd7, 1'b0);
        drain();
    endtask

    task automatic test_back_to_back();
        send(4'h6, 4'h1, 64'd5, 64'd2, 64'd0, 1'b0);
        send(4'h7, 4'h2, 64'd0, 64'd0, 64'd0, 1'b0);
        send(4'h6, 4'h0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFD, 64'd0, 1'b1);
        send(4'h7, 4'h3, 64'd0, 64'd0, 64'd0, 1'b0);
        drain();
    endtask

    task automatic test_errors();
        send(4'hC, 4'h0, 64'd1, 64'd2, 64'd3, 1'b0);
        send(4'hF, 4'h0, 64'd1, 64'd2, 64'd3, 1'b0);
        send(4'h6, 4'h5, 64'd1, 64'd1, 64'd0, 1'b0);
        send(4'h7, 4'h9, 64'd0, 64'd0, 64'd0, 1'b0);
        send(4'h2, 4'h7, 64'h33, 64'd0, 64'd0, 1'b0);
        drain();
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        send(4'h6, 4'h0, 64'd3, 64'd4, 64'd0, 1'b0);
        fork
            send(4'h3, 4'h0, 64'd0, 64'd0, 64'h55, 1'b0);
            begin
                repeat (2) begin
                    @(negedge clk);
                    total++;
                    if ({in_ready, out_valid, valE, out_icode, cc} !== {1'b0, 1'b1, 64'd7, 4'h6, 3'b000}) begin
                        bad++;
                        $display("FAIL stall_freeze: rdy=%b valid=%b valE=%h ic=%h cc=%b required 0 1 7 6 000",
                                 in_ready, out_valid, valE, out_icode, cc);
                    end
                end
                @(posedge clk); #1 out_ready = 1'b1;
            end
        join
        drain();
    endtask

    task automatic test_reset_mid_stall();
        out_ready = 1'b0;
        send(4'h6, 4'h1, 64'd1, 64'd0, 64'd0, 1'b0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if ({out_valid, in_ready, cc, valE, out_icode, cnd, out_err} !== {1'b0, 1'b1, 3'b100, 64'd0, 4'd0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_mid_stall: valid=%b rdy=%b cc=%b valE=%h ic=%h cnd=%b err=%b required 0 1 100 0 0 0 0",
                     out_valid, in_ready, cc, valE, out_icode, cnd, out_err);
        end
        sb.delete();
        m_cc = 3'b100;
        @(posedge clk); #1 rst = 1'b0; out_ready = 1'b1;
        send(4'h7, 4'h3, 64'd0, 64'd0, 64'd0, 1'b0);
        drain();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; cc_hold = 1'b0;
        icode = 4'd0; ifun = 4'd0; valA = 64'd0; valB = 64'd0; valC = 64'd0;
        m_cc = 3'b100;
        fork
            forever begin
                exp_t e, got;
                @(negedge clk);
                if (!rst && out_valid && out_ready) begin
                    total++;
                    got = '{icode: out_icode, vale: valE, cnd: cnd, err: out_err, cc: cc};
                    if (sb.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_result: icode=%h valE=%h with no pending expectation", out_icode, valE);
                    end else begin
                        e = sb.pop_front();
                        if (got !== e)
                            begin
                                bad++;
                                $display("FAIL result: got ic=%h valE=%h cnd=%b err=%b cc=%b required ic=%h valE=%h cnd=%b err=%b cc=%b",
                                         got.icode, got.vale, got.cnd, got.err, got.cc, e.icode, e.vale, e.cnd, e.err, e.cc);
                            end
                    end
                end
            end
        join_none
        test_reset();
        test_alu();
        test_addr();
        test_back_to_back();
        test_errors();
        test_stall();
        test_reset_mid_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
